// File: rtl/fetch_unit.sv
// Fetch stage: one outstanding read per PC value, IR handed to decode, redirect with flush.
// Latency: request accepted in N, response in N+1, ir_valid visible from N+2; stalls on mem_req_ready / ir_ready.
// Optional WAIT timeout with sticky fetch_err when FETCH_TIMEOUT_EN is defined.
module fetch_unit #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 8
) (
    input  logic              clk,
    input  logic              re_n,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_incre,
    output logic              pc_load_sel,
    output logic [ADDR_W-1:0] pc_load,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [DATA_W-1:0] ir,
    output logic              fetch_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t            r_state;
    logic              r_pc_incre;
    logic              r_pc_load_sel;
    logic [ADDR_W-1:0] r_pc_load;
    logic              r_mem_req_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_ir_valid;
    logic [DATA_W-1:0] r_ir;
    logic              r_flush;

`ifdef FETCH_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_fetch_err;
`endif

    always_ff @(posedge clk or negedge re_n) begin
        if (!re_n) begin
            r_state         <= S_IDLE;
            r_pc_incre      <= 1'b0;
            r_pc_load_sel   <= 1'b0;
            r_pc_load       <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= '0;
            r_ir_valid      <= 1'b0;
            r_ir            <= '0;
            r_flush         <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            r_tmo_cnt       <= '0;
            r_fetch_err     <= 1'b0;
`endif
        end else begin
            r_pc_incre    <= 1'b0;
            r_pc_load_sel <= 1'b0;
            if (redirect_valid) begin
                r_pc_load_sel <= 1'b1;
                r_pc_load     <= redirect_addr;
            end
            case (r_state)
                S_IDLE: begin
                    // PC updates on the edge that ends an incre/load pulse, so sample it only afterwards
                    if (!redirect_valid && !r_pc_incre && !r_pc_load_sel) begin
                        r_mem_addr      <= pc_in;
                        r_mem_req_valid <= 1'b1;
                        r_state         <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (redirect_valid)
                        r_flush <= 1'b1;
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                        r_tmo_cnt       <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (r_flush || redirect_valid) begin
                            r_flush <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_ir       <= mem_rsp_data;
                            r_ir_valid <= 1'b1;
                            r_pc_incre <= 1'b1;
                            r_state    <= S_HOLD;
                        end
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_LAST) begin
                        r_fetch_err <= 1'b1;
                        r_flush     <= 1'b0;
                        r_state     <= S_IDLE;
                    end
`endif
                    else begin
`ifdef FETCH_TIMEOUT_EN
                        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
`endif
                        if (redirect_valid)
                            r_flush <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || ir_ready) begin
                        r_ir_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pc_incre      = r_pc_incre;
    assign pc_load_sel   = r_pc_load_sel;
    assign pc_load       = r_pc_load;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_mem_addr;
    assign ir_valid      = r_ir_valid;
    assign ir            = r_ir;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err     = r_fetch_err;
`else
    assign fetch_err     = 1'b0;
`endif

endmodule
